// File: rtl/ceres_wrapper_pkg.sv
// Shared types and constants for the Ceres SoC board shell: loader/receiver
// states, reset-stretch length and the port bundles exchanged with ceres_soc.
package ceres_wrapper_pkg;

    localparam int RST_STRETCH = 16;
    localparam int RST_CNT_W   = $clog2(RST_STRETCH + 1);

    // Synchroniser bundle: prog_rx, uart_rx, miso, sda, scl, gpio[32], irq[8]
    localparam int SYNC_W = 45;

    typedef enum logic [1:0] {
        L_HUNT,
        L_LEN,
        L_DATA
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic        core_rst_n;
        logic        prog_we;
        logic [31:0] prog_addr;
        logic [31:0] prog_wdata;
        logic        uart_rx;
        logic        spi_miso;
        logic [31:0] gpio_in;
        logic [7:0]  ext_irq;
        logic        sda_in;
        logic        scl_in;
    } soc_in_t;

    typedef struct packed {
        logic        uart_tx;
        logic        spi_sclk;
        logic        spi_mosi;
        logic [3:0]  spi_ss;
        logic [31:0] gpio_out;
        logic [31:0] gpio_oe;
        logic        sda_oe;
        logic        scl_oe;
    } soc_out_t;

    function automatic logic [7:0] magic_byte(input logic [31:0] magic,
                                              input logic [1:0]  idx);
        return magic[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ceres_prog_loader.sv
// UART boot-loader: 8N1 receiver, magic/length/data FSM and the 32-bit
// program-memory write port.
module ceres_prog_loader
    import ceres_wrapper_pkg::*;
#(
    parameter int          CLK_FREQ   = 100_000_000,
    parameter int          PROG_BAUD  = 115200,
    parameter logic [31:0] PROG_MAGIC = 32'h5352_4543
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        prog_we,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_wdata,
    output logic        prog_mode
);

    localparam int BIT_CYCLES  = CLK_FREQ / PROG_BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             rx_prev_reg;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_reg   <= RX_IDLE;
            bit_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            rx_prev_reg    <= 1'b1;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            bit_cnt_reg    <= bit_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            rx_prev_reg    <= rx;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state_reg;
        bit_cnt_next    = bit_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx) begin
                    rx_state_next = RX_START;
                    bit_cnt_next  = '0;
                end
            end
            RX_START: begin
                if (bit_cnt_reg == HALF_LAST) begin
                    bit_cnt_next  = '0;
                    bit_idx_next  = '0;
                    // A glitch that is gone by mid start bit is not a frame.
                    rx_state_next = rx ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = '0;
                    shift_next   = {rx, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next    = '0;
                    rx_state_next   = RX_IDLE;
                    byte_valid_next = rx;
                    frame_err_next  = !rx;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    loader_state_t state_reg, state_next;
    logic [1:0]    match_reg, match_next;
    logic [1:0]    len_idx_reg, len_idx_next;
    logic [31:0]   len_reg, len_next;
    logic [31:0]   remain_reg, remain_next;
    logic [1:0]    lane_reg, lane_next;
    logic [31:0]   word_reg, word_next;
    logic [31:0]   addr_reg, addr_next;
    logic          we_reg, we_next;
    logic [31:0]   waddr_reg, waddr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [31:0]   len_full;
    logic [31:0]   word_merged;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= L_HUNT;
            match_reg   <= '0;
            len_idx_reg <= '0;
            len_reg     <= '0;
            remain_reg  <= '0;
            lane_reg    <= '0;
            word_reg    <= '0;
            addr_reg    <= '0;
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            match_reg   <= match_next;
            len_idx_reg <= len_idx_next;
            len_reg     <= len_next;
            remain_reg  <= remain_next;
            lane_reg    <= lane_next;
            word_reg    <= word_next;
            addr_reg    <= addr_next;
            we_reg      <= we_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
        end
    end

    assign len_full    = {shift_reg, len_reg[31:8]};
    assign word_merged = word_reg | (32'(shift_reg) << {lane_reg, 3'b000});

    always_comb begin
        state_next   = state_reg;
        match_next   = match_reg;
        len_idx_next = len_idx_reg;
        len_next     = len_reg;
        remain_next  = remain_reg;
        lane_next    = lane_reg;
        word_next    = word_reg;
        addr_next    = addr_reg;
        we_next      = 1'b0;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
        if (frame_err_reg) begin
            state_next = L_HUNT;
            match_next = '0;
        end else if (byte_valid_reg) begin
            case (state_reg)
                L_HUNT: begin
                    if (shift_reg == magic_byte(PROG_MAGIC, match_reg)) begin
                        if (match_reg == 2'd3) begin
                            state_next   = L_LEN;
                            match_next   = '0;
                            len_idx_next = '0;
                        end else begin
                            match_next = match_reg + 1'b1;
                        end
                    end else begin
                        // The failing byte may itself start a new magic sequence.
                        match_next = (shift_reg == magic_byte(PROG_MAGIC, 2'd0)) ? 2'd1 : 2'd0;
                    end
                end
                L_LEN: begin
                    len_next = len_full;
                    if (len_idx_reg == 2'd3) begin
                        if (len_full == 32'd0) begin
                            state_next = L_HUNT;
                        end else begin
                            state_next  = L_DATA;
                            remain_next = len_full;
                            lane_next   = '0;
                            word_next   = '0;
                            addr_next   = '0;
                        end
                    end else begin
                        len_idx_next = len_idx_reg + 1'b1;
                    end
                end
                L_DATA: begin
                    remain_next = remain_reg - 32'd1;
                    if ((lane_reg == 2'd3) || (remain_reg == 32'd1)) begin
                        we_next    = 1'b1;
                        waddr_next = addr_reg;
                        wdata_next = word_merged;
                        addr_next  = addr_reg + 32'd4;
                        lane_next  = '0;
                        word_next  = '0;
                    end else begin
                        lane_next = lane_reg + 1'b1;
                        word_next = word_merged;
                    end
                    if (remain_reg == 32'd1) begin
                        state_next = L_HUNT;
                    end
                end
                default: state_next = L_HUNT;
            endcase
        end
    end

    assign prog_we    = we_reg;
    assign prog_addr  = waddr_reg;
    assign prog_wdata = wdata_reg;
    assign prog_mode  = (state_reg != L_HUNT);

endmodule

// File: rtl/ceres_soc.sv
// Minimal stand-in for the Ceres core: program RAM written by the loader,
// pins looped back through registers so the shell can be exercised.
module ceres_soc
    import ceres_wrapper_pkg::*;
(
    input  logic     clk,
    input  soc_in_t  soc_i,
    output soc_out_t soc_o
);

    logic [31:0] prog_mem [256];
    logic [31:0] mem_rd_reg;
    soc_out_t    out_reg;

    // Program RAM is written regardless of core reset: loading happens while held.
    always_ff @(posedge clk) begin
        if (soc_i.prog_we && (soc_i.prog_addr[31:10] == 22'd0)
                && (soc_i.prog_addr[1:0] == 2'b00)) begin
            prog_mem[soc_i.prog_addr[9:2]] <= soc_i.prog_wdata;
        end
        mem_rd_reg <= prog_mem[soc_i.gpio_in[9:2]];
    end

    always_ff @(posedge clk) begin
        if (!soc_i.core_rst_n) begin
            out_reg.uart_tx  <= 1'b1;
            out_reg.spi_sclk <= 1'b0;
            out_reg.spi_mosi <= 1'b0;
            out_reg.spi_ss   <= 4'hF;
            out_reg.gpio_out <= '0;
            out_reg.gpio_oe  <= '0;
            out_reg.sda_oe   <= 1'b0;
            out_reg.scl_oe   <= 1'b0;
        end else begin
            out_reg.uart_tx  <= soc_i.uart_rx;
            out_reg.spi_sclk <= soc_i.gpio_in[30];
            out_reg.spi_mosi <= soc_i.spi_miso;
            out_reg.spi_ss   <= {soc_i.gpio_in[29:28], soc_i.scl_in, soc_i.sda_in};
            out_reg.gpio_out <= soc_i.gpio_in[31] ? mem_rd_reg : soc_i.gpio_in;
            out_reg.gpio_oe  <= {soc_i.ext_irq, 24'hFF_FFFF};
            out_reg.sda_oe   <= soc_i.gpio_in[0];
            out_reg.scl_oe   <= soc_i.gpio_in[1];
        end
    end

    assign soc_o = out_reg;

endmodule

// File: rtl/ceres_soc_wrapper.sv
// Board shell for the Ceres SoC: input synchronisers, core reset sequencing,
// UART boot-loader, pin gating during reset, I2C open-drain pads and LEDs.
module ceres_soc_wrapper
    import ceres_wrapper_pkg::*;
#(
    parameter int          CLK_FREQ   = 100_000_000,
    parameter int          PROG_BAUD  = 115200,
    parameter logic [31:0] PROG_MAGIC = 32'h5352_4543,
    parameter int          GPIO_EN    = 1,
    parameter int          HB_BITS    = 24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        program_rx_i,
    output logic        prog_mode_led_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i,
    output logic        spi0_sclk_o,
    output logic        spi0_mosi_o,
    input  logic        spi0_miso_i,
    output logic [3:0]  spi0_ss_o,
    inout  wire         i2c0_sda_io,
    inout  wire         i2c0_scl_io,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic [31:0] gpio_oe_o,
    input  logic [7:0]  ext_irq_i,
    output logic [3:0]  status_led_o
);

    localparam logic GPIO_ON = (GPIO_EN != 0);
    // Idle-high lines (both RX lines and the I2C pads) reset to 1.
    localparam logic [SYNC_W-1:0] SYNC_RST = {40'd0, 5'b11011};

    logic [SYNC_W-1:0] sync_in;
    logic [SYNC_W-1:0] sync_out;

    assign sync_in = {ext_irq_i, gpio_i, i2c0_scl_io, i2c0_sda_io,
                      spi0_miso_i, uart_rx_i, program_rx_i};

    for (genvar gi = 0; gi < SYNC_W; gi++) begin : g_sync
        logic [1:0] chain_reg;
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                chain_reg <= {2{SYNC_RST[gi]}};
            end else begin
                chain_reg <= {chain_reg[0], sync_in[gi]};
            end
        end
        assign sync_out[gi] = chain_reg[1];
    end

    logic        prog_rx_s, uart_rx_s, miso_s, sda_s, scl_s;
    logic [31:0] gpio_s;
    logic [7:0]  irq_s;

    assign prog_rx_s = sync_out[0];
    assign uart_rx_s = sync_out[1];
    assign miso_s    = sync_out[2];
    assign sda_s     = sync_out[3];
    assign scl_s     = sync_out[4];
    assign gpio_s    = sync_out[36:5];
    assign irq_s     = sync_out[44:37];

    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;
    logic        prog_mode;

    ceres_prog_loader #(
        .CLK_FREQ   (CLK_FREQ),
        .PROG_BAUD  (PROG_BAUD),
        .PROG_MAGIC (PROG_MAGIC)
    ) u_loader (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .rx         (prog_rx_s),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_mode  (prog_mode)
    );

    // Programming mode restarts the stretch, so the core gets a clean reset after loading.
    logic [RST_CNT_W-1:0] rst_cnt_reg, rst_cnt_next;
    logic                 core_rst_n_reg;

    assign rst_cnt_next = (rst_cnt_reg == RST_CNT_W'(RST_STRETCH)) ?
                          rst_cnt_reg : rst_cnt_reg + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || prog_mode) begin
            rst_cnt_reg    <= '0;
            core_rst_n_reg <= 1'b0;
        end else begin
            rst_cnt_reg    <= rst_cnt_next;
            core_rst_n_reg <= (rst_cnt_next == RST_CNT_W'(RST_STRETCH));
        end
    end

    logic [HB_BITS-1:0] hb_reg;
    logic               irq_or_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hb_reg     <= '0;
            irq_or_reg <= 1'b0;
        end else begin
            hb_reg     <= hb_reg + 1'b1;
            irq_or_reg <= |irq_s;
        end
    end

    soc_in_t  soc_in;
    soc_out_t soc_out;

    assign soc_in.core_rst_n = core_rst_n_reg;
    assign soc_in.prog_we    = prog_we;
    assign soc_in.prog_addr  = prog_addr;
    assign soc_in.prog_wdata = prog_wdata;
    assign soc_in.uart_rx    = uart_rx_s;
    assign soc_in.spi_miso   = miso_s;
    assign soc_in.gpio_in    = gpio_s;
    assign soc_in.ext_irq    = irq_s;
    assign soc_in.sda_in     = sda_s;
    assign soc_in.scl_in     = scl_s;

    ceres_soc u_soc (
        .clk   (clk_i),
        .soc_i (soc_in),
        .soc_o (soc_out)
    );

    assign uart_tx_o   = core_rst_n_reg ? soc_out.uart_tx  : 1'b1;
    assign spi0_sclk_o = core_rst_n_reg ? soc_out.spi_sclk : 1'b0;
    assign spi0_mosi_o = core_rst_n_reg ? soc_out.spi_mosi : 1'b0;
    assign spi0_ss_o   = core_rst_n_reg ? soc_out.spi_ss   : 4'hF;
    assign gpio_o      = (core_rst_n_reg && GPIO_ON) ? soc_out.gpio_out : 32'd0;
    assign gpio_oe_o   = (core_rst_n_reg && GPIO_ON) ? soc_out.gpio_oe  : 32'd0;

    assign i2c0_sda_io = (core_rst_n_reg && soc_out.sda_oe) ? 1'b0 : 1'bz;
    assign i2c0_scl_io = (core_rst_n_reg && soc_out.scl_oe) ? 1'b0 : 1'bz;

    assign prog_mode_led_o = prog_mode;
    assign status_led_o    = {irq_or_reg, ~core_rst_n_reg, prog_mode, hb_reg[HB_BITS-1]};

endmodule

// File: tb/tb_ceres_soc_wrapper.sv
// Directed bench for ceres_soc_wrapper: reset values, boot-loader framing and
// writes, reset abort, I2C pads, GPIO gating and interrupt LED latency.
module tb_ceres_soc_wrapper;

    localparam int BIT = 16;

    logic        clk;
    logic        rst_ni;
    logic        program_rx_i;
    logic        uart_rx_i;
    logic        spi0_miso_i;
    logic [31:0] gpio_i;
    logic [7:0]  ext_irq_i;
    logic        ng_rx;

    logic        prog_mode_led_o, uart_tx_o, spi0_sclk_o, spi0_mosi_o;
    logic [3:0]  spi0_ss_o, status_led_o;
    logic [31:0] gpio_o, gpio_oe_o;
    wire         sda_w, scl_w;

    logic        ng_led, ng_tx, ng_sclk, ng_mosi;
    logic [3:0]  ng_ss, ng_status;
    logic [31:0] ng_gpio, ng_gpio_oe;
    wire         ng_sda_w, ng_scl_w;

    pullup (sda_w);
    pullup (scl_w);
    pullup (ng_sda_w);
    pullup (ng_scl_w);

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    ceres_soc_wrapper #(
        .CLK_FREQ (1_600_000), .PROG_BAUD (100_000), .PROG_MAGIC (32'h5352_4543),
        .GPIO_EN (1), .HB_BITS (8)
    ) dut (
        .clk_i (clk), .rst_ni (rst_ni), .program_rx_i (program_rx_i),
        .prog_mode_led_o (prog_mode_led_o), .uart_tx_o (uart_tx_o),
        .uart_rx_i (uart_rx_i), .spi0_sclk_o (spi0_sclk_o),
        .spi0_mosi_o (spi0_mosi_o), .spi0_miso_i (spi0_miso_i),
        .spi0_ss_o (spi0_ss_o), .i2c0_sda_io (sda_w), .i2c0_scl_io (scl_w),
        .gpio_i (gpio_i), .gpio_o (gpio_o), .gpio_oe_o (gpio_oe_o),
        .ext_irq_i (ext_irq_i), .status_led_o (status_led_o)
    );

    ceres_soc_wrapper #(
        .CLK_FREQ (1_600_000), .PROG_BAUD (100_000), .PROG_MAGIC (32'h5352_4543),
        .GPIO_EN (0), .HB_BITS (8)
    ) dut_ng (
        .clk_i (clk), .rst_ni (rst_ni), .program_rx_i (ng_rx),
        .prog_mode_led_o (ng_led), .uart_tx_o (ng_tx),
        .uart_rx_i (uart_rx_i), .spi0_sclk_o (ng_sclk),
        .spi0_mosi_o (ng_mosi), .spi0_miso_i (spi0_miso_i),
        .spi0_ss_o (ng_ss), .i2c0_sda_io (ng_sda_w), .i2c0_scl_io (ng_scl_w),
        .gpio_i (gpio_i), .gpio_o (ng_gpio), .gpio_oe_o (ng_gpio_oe),
        .ext_irq_i (ext_irq_i), .status_led_o (ng_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (dut.prog_we) begin
            wr_addr_q.push_back(dut.prog_addr);
            wr_data_q.push_back(dut.prog_wdata);
            $display("write addr=%h data=%h", dut.prog_addr, dut.prog_wdata);
        end
    end

    initial begin
        #500_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        program_rx_i = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            program_rx_i = b[i];
            tick(BIT);
        end
        program_rx_i = stop;
        tick(BIT);
        program_rx_i = 1'b1;
        tick(4);
        $display("sent byte %h stop=%0b led=%0b", b, stop, prog_mode_led_o);
    endtask

    task automatic send_magic();
        send_byte(8'h43, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h53, 1'b1);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        n_checks++;
        if (prog_mode_led_o !== 1'b0 || uart_tx_o !== 1'b1 || spi0_sclk_o !== 1'b0 ||
            spi0_mosi_o !== 1'b0 || spi0_ss_o !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_pins: got led=%b tx=%b sclk=%b mosi=%b ss=%h expected 0 1 0 0 f",
                     prog_mode_led_o, uart_tx_o, spi0_sclk_o, spi0_mosi_o, spi0_ss_o);
        end
        n_checks++;
        if (gpio_o !== 32'd0 || gpio_oe_o !== 32'd0 || status_led_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_gpio_led: got gpio=%h oe=%h led=%b expected 0 0 0100",
                     gpio_o, gpio_oe_o, status_led_o);
        end
        n_checks++;
        if (sda_w !== 1'b1 || scl_w !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_i2c: got sda=%b scl=%b expected 1 1", sda_w, scl_w);
        end
        tick(15);
        n_checks++;
        if (status_led_o[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL stretch_15: got %b expected 1", status_led_o[2]);
        end
        tick(1);
        n_checks++;
        if (status_led_o[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL stretch_16: got %b expected 0", status_led_o[2]);
        end
        tick(111);
        n_checks++;
        if (status_led_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL heartbeat_127: got %b expected 0", status_led_o[0]);
        end
        tick(1);
        n_checks++;
        if (status_led_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL heartbeat_128: got %b expected 1", status_led_o[0]);
        end
        $display("reset test done");
    endtask

    task automatic test_load_basic();
        logic [7:0] data [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        wr_addr_q.delete();
        wr_data_q.delete();
        send_magic();
        n_checks++;
        if (prog_mode_led_o !== 1'b1 || status_led_o[2:1] !== 2'b11) begin
            n_fail++;
            $display("FAIL enter_prog: got led=%b status=%b expected 1 x11x",
                     prog_mode_led_o, status_led_o);
        end
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_byte(data[i], 1'b1);
            if (i == 6) begin
                n_checks++;
                if (prog_mode_led_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL led_during_data: got %b expected 1", prog_mode_led_o);
                end
            end
        end
        n_checks++;
        if (prog_mode_led_o !== 1'b0 || status_led_o[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_prog: got led=%b core_rst=%b expected 0 1",
                     prog_mode_led_o, status_led_o[2]);
        end
        n_checks++;
        if (wr_addr_q.size() !== 2) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d expected 2", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'h4433_2211 ||
                wr_addr_q[1] !== 32'd4 || wr_data_q[1] !== 32'h8877_6655) begin
                n_fail++;
                $display("FAIL basic_writes: got %h@%h %h@%h expected 44332211@0 88776655@4",
                         wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
            end
        end
        tick(20);
        n_checks++;
        if (status_led_o[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL core_release_after_load: got %b expected 0", status_led_o[2]);
        end
        gpio_i = 32'h8000_0004;
        tick(8);
        n_checks++;
        if (gpio_o !== 32'h8877_6655) begin
            n_fail++;
            $display("FAIL readback_word1: got %h expected 88776655", gpio_o);
        end
        gpio_i = 32'h8000_0000;
        tick(8);
        n_checks++;
        if (gpio_o !== 32'h4433_2211) begin
            n_fail++;
            $display("FAIL readback_word0: got %h expected 44332211", gpio_o);
        end
        gpio_i = 32'd0;
        tick(4);
    endtask

    task automatic test_overlap_abort();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h43, 1'b1);
        send_magic();
        n_checks++;
        if (prog_mode_led_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overlap_entry: got %b expected 1", prog_mode_led_o);
        end
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        rst_ni = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        n_checks++;
        if (prog_mode_led_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_led: got %b expected 0", prog_mode_led_o);
        end
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        n_checks++;
        if (wr_addr_q.size() !== 0 || prog_mode_led_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_write: got writes=%0d led=%b expected 0 0",
                     wr_addr_q.size(), prog_mode_led_o);
        end
    endtask

    task automatic test_framing();
        send_byte(8'h43, 1'b0);
        send_byte(8'h45, 1'b1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h53, 1'b1);
        n_checks++;
        if (prog_mode_led_o !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_no_entry: got %b expected 0", prog_mode_led_o);
        end
    endtask

    task automatic test_short_len();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_magic();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1);
        end
        n_checks++;
        if (wr_addr_q.size() !== 2) begin
            n_fail++;
            $display("FAIL short_write_count: got %0d expected 2", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'h0403_0201 ||
                wr_addr_q[1] !== 32'd4 || wr_data_q[1] !== 32'h0000_0005) begin
                n_fail++;
                $display("FAIL short_writes: got %h@%h %h@%h expected 04030201@0 00000005@4",
                         wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
            end
        end
        n_checks++;
        if (prog_mode_led_o !== 1'b0) begin
            n_fail++;
            $display("FAIL short_exit: got %b expected 0", prog_mode_led_o);
        end
        tick(20);
    endtask

    task automatic test_pins();
        gpio_i = 32'h0000_5A00;
        tick(8);
        n_checks++;
        if (gpio_o !== 32'h0000_5A00 || gpio_oe_o !== 32'h00FF_FFFF) begin
            n_fail++;
            $display("FAIL gpio_enabled: got %h/%h expected 00005a00/00ffffff", gpio_o, gpio_oe_o);
        end
        n_checks++;
        if (ng_gpio !== 32'd0 || ng_gpio_oe !== 32'd0) begin
            n_fail++;
            $display("FAIL gpio_disabled: got %h/%h expected 0/0", ng_gpio, ng_gpio_oe);
        end
        gpio_i = 32'h0000_5A01;
        tick(8);
        n_checks++;
        if (sda_w !== 1'b0 || scl_w !== 1'b1) begin
            n_fail++;
            $display("FAIL sda_drive: got sda=%b scl=%b expected 0 1", sda_w, scl_w);
        end
        gpio_i = 32'h0000_5A02;
        tick(8);
        n_checks++;
        if (sda_w !== 1'b1 || scl_w !== 1'b0) begin
            n_fail++;
            $display("FAIL scl_drive: got sda=%b scl=%b expected 1 0", sda_w, scl_w);
        end
        gpio_i = 32'd0;
        uart_rx_i = 1'b0;
        spi0_miso_i = 1'b1;
        tick(8);
        n_checks++;
        if (sda_w !== 1'b1 || scl_w !== 1'b1 || uart_tx_o !== 1'b0 || spi0_mosi_o !== 1'b1) begin
            n_fail++;
            $display("FAIL release_uart_spi: got sda=%b scl=%b tx=%b mosi=%b expected 1 1 0 1",
                     sda_w, scl_w, uart_tx_o, spi0_mosi_o);
        end
        uart_rx_i = 1'b1;
        spi0_miso_i = 1'b0;
        tick(4);
    endtask

    task automatic test_irq();
        ext_irq_i = 8'h04;
        tick(2);
        n_checks++;
        if (status_led_o[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early: got %b expected 0", status_led_o[3]);
        end
        tick(1);
        n_checks++;
        if (status_led_o[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set: got %b expected 1", status_led_o[3]);
        end
        ext_irq_i = 8'h00;
        tick(3);
        n_checks++;
        if (status_led_o[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got %b expected 0", status_led_o[3]);
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        program_rx_i = 1'b1;
        ng_rx        = 1'b1;
        uart_rx_i    = 1'b1;
        spi0_miso_i  = 1'b0;
        gpio_i       = 32'd0;
        ext_irq_i    = 8'd0;
        test_reset();
        test_load_basic();
        test_overlap_abort();
        test_framing();
        test_short_len();
        test_pins();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
